// File: rtl/level_crossing_detector.sv
// Hysteresis level detector on the averaged sample stream with an N-sample debounce,
// registered level flag, single-cycle rise/fall pulses and a saturating dwell counter.
module level_crossing_detector #(
  parameter logic signed [7:0] HI_THRESH = 8'sd20,
  parameter logic signed [7:0] LO_THRESH = -8'sd20,
  parameter int unsigned       HOLD      = 3,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic [7:0]       sample_i,
  input  logic             sample_valid_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] dwell_o
);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    ARM_HI = 2'd1,
    HIGH   = 2'd2,
    ARM_LO = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_C = 4'(HOLD);

  state_t             state, state_n;
  logic [3:0]         hold, hold_n;
  logic               level_n, rise_n, fall_n;
  logic [CNT_W-1:0]   dwell_n;
  logic signed [7:0]  sample_s;
  logic               is_hi, is_lo;

  assign sample_s = $signed(sample_i);
  assign is_hi    = (sample_s >= HI_THRESH);
  assign is_lo    = (sample_s <= LO_THRESH);

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state   <= LOW;
      hold    <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      dwell_o <= '0;
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      level_o <= level_n;
      rise_o  <= rise_n;
      fall_o  <= fall_n;
      dwell_o <= dwell_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    dwell_n = dwell_o;
    if (sample_valid_i) begin
      // Increment by default; a completed transition overrides this with zero below.
      dwell_n = (dwell_o == '1) ? dwell_o : dwell_o + CNT_W'(1);
      unique case (state)
        LOW: begin
          if (is_hi) begin
            if (HOLD_C == 4'd1) begin
              state_n = HIGH;
              hold_n  = '0;
              rise_n  = 1'b1;
              dwell_n = '0;
            end else begin
              state_n = ARM_HI;
              hold_n  = 4'd1;
            end
          end
        end
        ARM_HI: begin
          if (is_hi) begin
            if (hold + 4'd1 == HOLD_C) begin
              state_n = HIGH;
              hold_n  = '0;
              rise_n  = 1'b1;
              dwell_n = '0;
            end else begin
              hold_n = hold + 4'd1;
            end
          end else begin
            state_n = LOW;
            hold_n  = '0;
          end
        end
        HIGH: begin
          if (is_lo) begin
            if (HOLD_C == 4'd1) begin
              state_n = LOW;
              hold_n  = '0;
              fall_n  = 1'b1;
              dwell_n = '0;
            end else begin
              state_n = ARM_LO;
              hold_n  = 4'd1;
            end
          end
        end
        ARM_LO: begin
          if (is_lo) begin
            if (hold + 4'd1 == HOLD_C) begin
              state_n = LOW;
              hold_n  = '0;
              fall_n  = 1'b1;
              dwell_n = '0;
            end else begin
              hold_n = hold + 4'd1;
            end
          end else begin
            state_n = HIGH;
            hold_n  = '0;
          end
        end
        default: begin
          state_n = LOW;
          hold_n  = '0;
        end
      endcase
    end
    level_n = (state_n == HIGH) || (state_n == ARM_LO);
  end

endmodule

// File: tb/tb_level_crossing_detector.sv
// Directed bench for level_crossing_detector: default HOLD=3 instance plus a HOLD=1 instance.
module tb_level_crossing_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = 8'd0;
  logic       valid  = 1'b0;
  logic       valid1 = 1'b0;

  logic       level, rise, fall;
  logic [7:0] dwell;
  logic       level1, rise1, fall1;
  logic [7:0] dwell1;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  level_crossing_detector #(
    .HI_THRESH(8'sd20),
    .LO_THRESH(-8'sd20),
    .HOLD(3),
    .CNT_W(8)
  ) dut (
    .system1000(clk),
    .system1000_rst(rst),
    .sample_i(sample),
    .sample_valid_i(valid),
    .level_o(level),
    .rise_o(rise),
    .fall_o(fall),
    .dwell_o(dwell)
  );

  level_crossing_detector #(
    .HI_THRESH(8'sd20),
    .LO_THRESH(-8'sd20),
    .HOLD(1),
    .CNT_W(8)
  ) dut1 (
    .system1000(clk),
    .system1000_rst(rst),
    .sample_i(sample),
    .sample_valid_i(valid1),
    .level_o(level1),
    .rise_o(rise1),
    .fall_o(fall1),
    .dwell_o(dwell1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
  task automatic step(input logic [7:0] s, input logic v);
    sample = s;
    valid  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic l, input logic r,
                          input logic f, input logic [7:0] d);
    chk({tag, ".level"}, 32'(level), 32'(l));
    chk({tag, ".rise"},  32'(rise),  32'(r));
    chk({tag, ".fall"},  32'(fall),  32'(f));
    chk({tag, ".dwell"}, 32'(dwell), 32'(d));
  endtask

  initial begin
    // Reset state
    #12;
    chk_main("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Five zero samples in LOW
    for (int i = 0; i < 5; i++) begin
      step(8'd0, 1'b1);
      chk("zeros.rise", 32'(rise), 32'd0);
    end
    chk_main("zeros", 1'b0, 1'b0, 1'b0, 8'd5);

    // Rise on third qualifying sample
    step(8'd25, 1'b1);  chk_main("rise.s1", 1'b0, 1'b0, 1'b0, 8'd6);
    step(8'd25, 1'b1);  chk_main("rise.s2", 1'b0, 1'b0, 1'b0, 8'd7);
    step(8'd25, 1'b1);  chk_main("rise.s3", 1'b1, 1'b1, 1'b0, 8'd0);
    step(8'd0, 1'b1);   chk_main("rise.after1", 1'b1, 1'b0, 1'b0, 8'd1);
    step(8'd0, 1'b1);   chk_main("rise.after2", 1'b1, 1'b0, 1'b0, 8'd2);

    // Arm toward LOW, then asynchronous reset mid-cycle
    step(8'hEC, 1'b1);  chk_main("arm_lo.s1", 1'b1, 1'b0, 1'b0, 8'd3);
    step(8'hEC, 1'b1);  chk_main("arm_lo.s2", 1'b1, 1'b0, 1'b0, 8'd4);
    #2;
    rst = 1'b1;
    #1;
    chk_main("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step(8'hEC, 1'b1);  chk_main("post_rst", 1'b0, 1'b0, 1'b0, 8'd1);

    // Abort on in-band sample restarts the count
    step(8'd25, 1'b1);  chk_main("abort.s1", 1'b0, 1'b0, 1'b0, 8'd2);
    step(8'd25, 1'b1);  chk_main("abort.s2", 1'b0, 1'b0, 1'b0, 8'd3);
    step(8'd10, 1'b1);  chk_main("abort.s3", 1'b0, 1'b0, 1'b0, 8'd4);
    step(8'd25, 1'b1);  chk_main("abort.s4", 1'b0, 1'b0, 1'b0, 8'd5);
    step(8'd25, 1'b1);  chk_main("abort.s5", 1'b0, 1'b0, 1'b0, 8'd6);
    step(8'd0, 1'b1);   chk_main("abort.s6", 1'b0, 1'b0, 1'b0, 8'd7);

    // Inclusive threshold with invalid cycles interleaved
    step(8'd20, 1'b1);  chk_main("incl.s1", 1'b0, 1'b0, 1'b0, 8'd8);
    for (int i = 0; i < 4; i++) begin
      step(8'd100, 1'b0);
      chk_main("incl.invalid", 1'b0, 1'b0, 1'b0, 8'd8);
    end
    step(8'd20, 1'b1);  chk_main("incl.s2", 1'b0, 1'b0, 1'b0, 8'd9);
    step(8'd20, 1'b1);  chk_main("incl.s3", 1'b1, 1'b1, 1'b0, 8'd0);
    step(8'd0, 1'b0);   chk_main("incl.after", 1'b1, 1'b0, 1'b0, 8'd0);

    // From HIGH: -19 does not qualify, -20 does
    step(8'hED, 1'b1);  chk_main("m19.s1", 1'b1, 1'b0, 1'b0, 8'd1);
    step(8'hED, 1'b1);  chk_main("m19.s2", 1'b1, 1'b0, 1'b0, 8'd2);
    step(8'hED, 1'b1);  chk_main("m19.s3", 1'b1, 1'b0, 1'b0, 8'd3);
    step(8'hEC, 1'b1);  chk_main("fall.s1", 1'b1, 1'b0, 1'b0, 8'd4);
    step(8'hEC, 1'b1);  chk_main("fall.s2", 1'b1, 1'b0, 1'b0, 8'd5);
    step(8'hEC, 1'b1);  chk_main("fall.s3", 1'b0, 1'b0, 1'b1, 8'd0);
    step(8'd0, 1'b0);   chk_main("fall.after", 1'b0, 1'b0, 1'b0, 8'd0);

    // Dwell saturation
    for (int i = 1; i <= 300; i++) begin
      step(8'd0, 1'b1);
      chk("sat.dwell", 32'(dwell), (i > 255) ? 32'd255 : 32'(i));
    end
    chk_main("sat.end", 1'b0, 1'b0, 1'b0, 8'd255);
    step(8'd25, 1'b1);  chk_main("sat.s1", 1'b0, 1'b0, 1'b0, 8'd255);
    step(8'd25, 1'b1);  chk_main("sat.s2", 1'b0, 1'b0, 1'b0, 8'd255);
    step(8'd25, 1'b1);  chk_main("sat.s3", 1'b1, 1'b1, 1'b0, 8'd0);

    // HOLD = 1 instance: 19 does not qualify, a single 20 rises at once
    valid1 = 1'b1;
    step(8'd19, 1'b0);
    chk("h1.s19.level", 32'(level1), 32'd0);
    chk("h1.s19.rise",  32'(rise1),  32'd0);
    chk("h1.s19.dwell", 32'(dwell1), 32'd1);
    step(8'd20, 1'b0);
    chk("h1.s20.level", 32'(level1), 32'd1);
    chk("h1.s20.rise",  32'(rise1),  32'd1);
    chk("h1.s20.dwell", 32'(dwell1), 32'd0);
    valid1 = 1'b0;
    step(8'd20, 1'b0);
    chk("h1.after.level", 32'(level1), 32'd1);
    chk("h1.after.rise",  32'(rise1),  32'd0);
    chk("h1.after.fall",  32'(fall1),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/level_crossing_detector.md
Name: level_crossing_detector

Overview:
- Downstream consumer of the 8-bit signed moving-average stage output.
- Detects threshold crossings with hysteresis and an N-sample debounce.
- Produces a registered level flag, single-cycle rise/fall event pulses and a saturating dwell counter for the downstream control/logging logic.
- Runs in the system1000 clock domain.

Parameters:
HI_THRESH, 20, signed 8-bit upper threshold; a sample qualifies high when sample_i >= HI_THRESH
LO_THRESH, -20, signed 8-bit lower threshold; a sample qualifies low when sample_i <= LO_THRESH; must be < HI_THRESH
HOLD, 3, consecutive qualifying valid samples required to switch level; legal range 1..15
CNT_W, 8, width of dwell_o

Ports:
system1000  in  1  clock, rising-edge active
system1000_rst  in  1  asynchronous active-high reset
sample_i  in  8  signed averaged sample from the moving-average stage
sample_valid_i  in  1  sample_i is accepted on a rising edge when this is 1
level_o  out  1  current debounced level: 0 = low, 1 = high
rise_o  out  1  one-cycle pulse on the low-to-high transition
fall_o  out  1  one-cycle pulse on the high-to-low transition
dwell_o  out  CNT_W  valid samples accepted since the last level transition; saturating

Behaviour:
- Reset (asynchronous, active-high, immediate at any time including mid-arming):
  - FSM = LOW; hold counter = 0.
  - level_o = 0, rise_o = 0, fall_o = 0, dwell_o = 0.
- Sample acceptance:
  - A sample is accepted only on a rising edge with sample_valid_i = 1.
  - Edges with sample_valid_i = 0 leave FSM state, hold counter, dwell_o and level_o unchanged.
  - rise_o and fall_o are always 0 on such edges.
- All comparisons are signed 8-bit. Thresholds are inclusive.
- FSM states: LOW, ARM_HI, HIGH, ARM_LO. level_o = 0 in LOW and ARM_HI; level_o = 1 in HIGH and ARM_LO.
- LOW:
  - Accepted sample >= HI_THRESH: if HOLD = 1, go to HIGH (transition); otherwise go to ARM_HI with hold = 1.
  - Any other accepted sample: stay in LOW.
- ARM_HI:
  - Accepted sample >= HI_THRESH: hold + 1. When hold + 1 = HOLD, go to HIGH (transition).
  - Accepted sample < HI_THRESH: go to LOW with hold = 0. This abort applies even when the sample is between the thresholds.
- HIGH and ARM_LO mirror LOW and ARM_HI, using sample <= LO_THRESH and going to LOW on completion.
- In LOW and HIGH, samples between the thresholds have no effect except incrementing dwell_o.
- Transition edge (the edge accepting the HOLD-th consecutive qualifying sample):
  - level_o toggles.
  - rise_o (to HIGH) or fall_o (to LOW) is 1 for exactly that one following clock cycle.
  - dwell_o = 0; hold = 0.
  - Latency is 1 clock from the qualifying sample edge to the outputs.
- dwell_o:
  - Every other accepted sample increments dwell_o by 1, saturating at 2^CNT_W - 1.
  - Arming states do not reset dwell_o; only a transition does.
- rise_o and fall_o are never asserted together. All outputs are registered.

Test Plan:
- Reset, then 5 valid samples of 0 -> level_o = 0, no pulses, dwell_o = 5. Assert reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
- Valid 25, 25, 25 from LOW -> rise_o high for exactly one cycle after the 3rd edge, level_o = 1, dwell_o = 0. Then 2 valid samples of 0 -> level_o stays 1, dwell_o = 2.
- Valid 25, 25, 10, 25, 25 -> no rise_o, level_o = 0, dwell_o = 5. The abort on 10 restarts the count.
- Valid 20, then 4 cycles with sample_valid_i = 0 and sample_i = 100, then valid 20, 20 -> rise_o exactly once, one cycle after the final valid edge (inclusive threshold; invalid cycles ignored).
- From HIGH: valid -20, -20, -20 -> fall_o one cycle, level_o = 0. Valid -19 x3 from HIGH -> no fall. Verify HOLD = 1 build: a single valid 20 -> immediate rise.
- 300 consecutive valid samples of 0 in LOW -> dwell_o saturates at 255 and stays there. Then valid 25 x3 -> dwell_o = 0 with rise_o.
